// File: rtl/if_stage_pkg.sv
// Shared constants and small helpers for the instruction-fetch stage.
package if_stage_pkg;

   localparam int unsigned       INST_W           = 32;
   localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;
   localparam logic [INST_W-1:0] PC_STEP          = 32'd4;

   function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
      return {addr[INST_W-1:2], 2'b00};
   endfunction

   function automatic logic is_misaligned(input logic [INST_W-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect priority selection plus a one-entry buffer that holds a redirect
// arriving while the fetch stage is stalled.
module pc_redirect_buf
   import if_stage_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              stall_i,
   input  logic              br_taken_i,
   input  logic [INST_W-1:0] br_target_i,
   input  logic              jump_i,
   input  logic [INST_W-1:0] jump_target_i,
   output logic              req_o,
   output logic              raw_misaligned_o,
   output logic              apply_o,
   output logic [INST_W-1:0] target_o
);

   logic              pend_v_q, pend_v_d;
   logic [INST_W-1:0] pend_t_q, pend_t_d;
   logic              req_s;
   logic              apply_s;
   logic [INST_W-1:0] raw_tgt_s;
   logic [INST_W-1:0] req_tgt_s;

   // Branch wins over jump (older instruction); a live request beats the buffer.
   always_comb begin
      req_s     = br_taken_i | jump_i;
      raw_tgt_s = br_taken_i ? br_target_i : jump_target_i;
      req_tgt_s = word_align(raw_tgt_s);
      apply_s   = ~stall_i & (req_s | pend_v_q);
      pend_v_d  = pend_v_q;
      pend_t_d  = pend_t_q;
      if (stall_i && req_s) begin
         pend_v_d = 1'b1;
         pend_t_d = req_tgt_s;
      end else if (apply_s) begin
         pend_v_d = 1'b0;
      end else begin
         pend_v_d = pend_v_q;
      end
   end

   // Pending-redirect register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pend_v_q <= 1'b0;
         pend_t_q <= {INST_W{1'b0}};
      end else begin
         pend_v_q <= pend_v_d;
         pend_t_q <= pend_t_d;
      end
   end

   assign req_o            = req_s;
   assign raw_misaligned_o = req_s & is_misaligned(raw_tgt_s);
   assign apply_o          = apply_s;
   assign target_o         = req_s ? req_tgt_s : pend_t_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect handling, fetch counter and
// sticky misaligned-target flag.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              stall_i,
   input  logic              br_taken_i,
   input  logic [INST_W-1:0] br_target_i,
   input  logic              jump_i,
   input  logic [INST_W-1:0] jump_target_i,
   output logic [INST_W-1:0] im_addr_o,
   input  logic [INST_W-1:0] im_data_i,
   output logic [INST_W-1:0] pc_o,
   output logic [INST_W-1:0] pc4_o,
   output logic [INST_W-1:0] inst_o,
   output logic              addr_err_o,
   output logic [INST_W-1:0] fetch_cnt_o
);

   logic [INST_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [INST_W-1:0] pc4_s;
   logic              req_s;
   logic              raw_mis_s;
   logic              apply_s;
   logic [INST_W-1:0] target_s;

   pc_redirect_buf u_redirect (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .stall_i          (stall_i),
      .br_taken_i       (br_taken_i),
      .br_target_i      (br_target_i),
      .jump_i           (jump_i),
      .jump_target_i    (jump_target_i),
      .req_o            (req_s),
      .raw_misaligned_o (raw_mis_s),
      .apply_o          (apply_s),
      .target_o         (target_s)
   );

   // Next PC, fetch count and error flag; the error flag ignores Stall.
   always_comb begin
      pc4_s = pc_q + PC_STEP;
      pc_d  = pc_q;
      cnt_d = cnt_q;
      err_d = err_q | raw_mis_s;
      if (stall_i) begin
         pc_d  = pc_q;
         cnt_d = cnt_q;
      end else if (apply_s) begin
         pc_d  = target_s;
         cnt_d = cnt_q;
      end else begin
         pc_d  = pc4_s;
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Architectural fetch-stage registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q  <= RESET_PC;
         cnt_q <= {INST_W{1'b0}};
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign im_addr_o   = pc_q;
   assign pc_o        = pc_q;
   assign pc4_o       = pc4_s;
   assign inst_o      = apply_s ? NOP_INST : im_data_i;
   assign addr_err_o  = err_q;
   assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios followed by random traffic,
// checked against a behavioural fetch-stage model.
module tb_if_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        err;
      logic [31:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset, stall, br_taken, jump;
   logic [31:0] br_target, jump_target;
   logic [31:0] im_addr, im_data, pc, pc4, inst, fetch_cnt;
   logic        addr_err;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t exp_q[$];

   // Reference model state.
   logic [31:0] m_pc;
   logic        m_pend_v;
   logic [31:0] m_pend_t;
   logic [31:0] m_cnt;
   logic        m_err;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .stall_i       (stall),
      .br_taken_i    (br_taken),
      .br_target_i   (br_target),
      .jump_i        (jump),
      .jump_target_i (jump_target),
      .im_addr_o     (im_addr),
      .im_data_i     (im_data),
      .pc_o          (pc),
      .pc4_o         (pc4),
      .inst_o        (inst),
      .addr_err_o    (addr_err),
      .fetch_cnt_o   (fetch_cnt)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign im_data = mem_word(im_addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pend_v = 1'b0; m_pend_t = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
   endtask

   // One cycle: apply inputs, push expectation, clock, advance model.
   task automatic drive(input logic r, input logic s, input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jtg);
      logic        req, apply;
      logic [31:0] raw, tgt;
      exp_t        e;
      reset = r; stall = s; br_taken = bt; br_target = btg; jump = j; jump_target = jtg;
      req   = bt | j;
      raw   = bt ? btg : jtg;
      tgt   = raw & 32'hFFFF_FFFC;
      apply = !s && (req || m_pend_v);
      e.pc   = m_pc;
      e.pc4  = m_pc + 32'd4;
      e.inst = apply ? 32'h0 : mem_word(m_pc);
      e.err  = m_err;
      e.cnt  = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (req && raw[1:0] != 2'b00) m_err = 1'b1;
         if (s) begin
            if (req) begin m_pend_v = 1'b1; m_pend_t = tgt; end
         end else if (apply) begin
            m_pc = req ? tgt : m_pend_t;
            m_pend_v = 1'b0;
         end else begin
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Monitor: compare every presented cycle against the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("pc",        pc,        e.pc);
         check("im_addr",   im_addr,   e.pc);
         check("pc4",       pc4,       e.pc4);
         check("inst",      inst,      e.inst);
         check("addr_err",  {31'd0, addr_err}, {31'd0, e.err});
         check("fetch_cnt", fetch_cnt, e.cnt);
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
      br_target = 32'h0; jump_target = 32'h0;
      @(posedge clk); #1;
      model_reset();

      // Straight-line fetch.
      idle(4);
      check("seq_pc", pc, 32'h10);
      check("seq_cnt", fetch_cnt, 32'd4);

      // Branch and jump together at PC=8: branch wins.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
      check("prio_pc", pc, 32'h40);
      check("prio_cnt", fetch_cnt, 32'd2);

      // Redirects buffered during a stall; the later one overwrites.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(4);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
      drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("stall_pc", pc, 32'h10);
      idle(1);
      check("pend_pc", pc, 32'h200);

      // Misaligned target sets sticky error.
      drive(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
      check("mis_pc", pc, 32'h40);
      idle(3);
      check("mis_err", {31'd0, addr_err}, 32'd1);

      // Reset discards a buffered redirect.
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(3);
      check("rst_pend_pc", pc, 32'hC);
      check("rst_err", {31'd0, addr_err}, 32'd0);

      // PC wrap at the top of the address space.
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      check("wrap_pc4", pc4, 32'h0);
      idle(1);
      check("wrap_pc", pc, 32'h0);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] bt_t, j_t;
         bt_t = $urandom;
         j_t  = $urandom;
         if ($urandom_range(0, 3) != 0) bt_t[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) j_t[1:0]  = 2'b00;
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 15, bt_t, $urandom_range(0, 99) < 15, j_t);
      end
      idle(1);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      check("drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
